// File: rtl/rotator_pipe_bidir.sv
`default_nettype none
// ============================================================================
//  Module   : rotator_pipe_bidir
//  Brief    : Three-stage valid/ready bidirectional barrel rotator. Right
//             rotation is built as rev(rotl(rev(x), k)) around a single
//             left-rotate core.
//  Revision : 1.0 - initial release
// ============================================================================
module rotator_pipe_bidir #(
    parameter int WIDTH = 8,
    parameter int SHW   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_amt,
    input  logic             in_dir,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    function automatic logic [WIDTH-1:0] f_rev(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] y;
        for (int i = 0; i < WIDTH; i++) begin
            y[i] = x[WIDTH-1-i];
        end
        return y;
    endfunction

    // Stage 1: pre-reverse
    logic             r_v1;
    logic [WIDTH-1:0] r_d1;
    logic [SHW-1:0]   r_a1;
    logic             r_dir1;
    // Stage 2: rotate (amount is consumed here, only direction travels on)
    logic             r_v2;
    logic [WIDTH-1:0] r_d2;
    logic             r_dir2;
    // Stage 3: post-reverse, drives the output
    logic             r_v3;
    logic [WIDTH-1:0] r_d3;

    logic w_rdy1;
    logic w_rdy2;
    logic w_rdy3;

    assign w_rdy3    = !r_v3 || out_ready;
    assign w_rdy2    = !r_v2 || w_rdy3;
    assign w_rdy1    = !r_v1 || w_rdy2;
    assign in_ready  = w_rdy1;
    assign out_valid = r_v3;
    assign out_data  = r_d3;
    assign busy      = r_v1 || r_v2 || r_v3;

    // Log-depth left rotator: level g rotates by 2**g when amount bit g is set
    logic [SHW:0][WIDTH-1:0] w_rot;
    assign w_rot[0] = r_d1;

    for (genvar g = 0; g < SHW; g++) begin : g_rot
        localparam int c_sh = 1 << g;
        assign w_rot[g+1] = r_a1[g]
            ? {w_rot[g][WIDTH-1-c_sh:0], w_rot[g][WIDTH-1:WIDTH-c_sh]}
            : w_rot[g];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1   <= 1'b0;
            r_d1   <= '0;
            r_a1   <= '0;
            r_dir1 <= 1'b0;
        end else if (w_rdy1) begin
            r_v1 <= in_valid;
            if (in_valid) begin
                r_d1   <= in_dir ? f_rev(in_data) : in_data;
                r_a1   <= in_amt;
                r_dir1 <= in_dir;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v2   <= 1'b0;
            r_d2   <= '0;
            r_dir2 <= 1'b0;
        end else if (w_rdy2) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_d2   <= w_rot[SHW];
                r_dir2 <= r_dir1;
            end
        end
    end

    // Data only moves with a valid beat so the output holds across bubbles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v3 <= 1'b0;
            r_d3 <= '0;
        end else if (w_rdy3) begin
            r_v3 <= r_v2;
            if (r_v2) begin
                r_d3 <= r_dir2 ? f_rev(r_d2) : r_d2;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rotator_pipe_bidir.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rotator_pipe_bidir
//  Brief    : Scoreboard bench for rotator_pipe_bidir with an arithmetic
//             rotate model and a decoupled output monitor.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rotator_pipe_bidir;

    localparam int W  = 8;
    localparam int SH = 3;

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic          in_valid  = 1'b0;
    logic [W-1:0]  in_data   = '0;
    logic [SH-1:0] in_amt    = '0;
    logic          in_dir    = 1'b0;
    logic          out_ready = 1'b1;
    logic          in_ready;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic          busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit rnd_or  = 1'b0;

    logic [W-1:0] exp_q[$];
    int           pop_cyc[$];
    logic         hold_pending = 1'b0;
    logic [W-1:0] hold_data    = '0;

    rotator_pipe_bidir #(.WIDTH(W), .SHW(SH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_dir    (in_dir),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (rnd_or) out_ready = 1'($urandom_range(0, 1));
    end

    // Rotation as plain integer arithmetic on the unmasked word
    function automatic logic [W-1:0] model(input int x, input int k, input logic dir);
        int r;
        if (!dir) r = (x << k) | (x >> (W - k));
        else      r = (x >> k) | (x << (W - k));
        return r[W-1:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic send(input logic [W-1:0] d, input int k, input logic dir);
        int t = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_amt   = k[SH-1:0];
        in_dir   = dir;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            t++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: in_ready got 0 expected 1 (cycle %0d)", cyc);
        end else begin
            exp_q.push_back(model(int'(d), k, dir));
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input int limit);
        int t = 0;
        while (exp_q.size() != 0 && t < limit) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: %0d beats outstanding expected 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard on every output transfer and checks stall stability
    always @(negedge clk) begin
        if (!rst) begin
            if (hold_pending) begin
                check("stall_hold_valid", 32'(out_valid), 32'd1);
                check("stall_hold_data", 32'(out_data), 32'(hold_data));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_output: got %0h with empty scoreboard", out_data);
                end else begin
                    check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
                    pop_cyc.push_back(cyc);
                end
            end
            hold_pending = out_valid && !out_ready;
            hold_data    = out_data;
        end else begin
            hold_pending = 1'b0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        logic [W-1:0] bd;
        rst       = 1'b1;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_data", 32'(out_data), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        #1;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Latency: three edges from input transfer to out_valid
        send(8'b1000_0000, 1, 1'b0);
        @(negedge clk);
        check("lat_c1_valid", 32'(out_valid), 32'd0);
        check("lat_c1_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("lat_c2_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("lat_c3_valid", 32'(out_valid), 32'd1);
        check("lat_c3_data", 32'(out_data), 32'h01);
        @(negedge clk);
        check("busy_after_drain", 32'(busy), 32'd0);
        @(posedge clk);
        #1;

        send(8'b1101_0100, 3, 1'b1);
        send(8'b0000_0001, 1, 1'b1);
        drain(50);

        // Back-to-back streaming, results must emerge on consecutive cycles
        n0 = pop_cyc.size();
        send(8'b1111_0000, 2, 1'b0);
        send(8'b1111_0000, 2, 1'b1);
        send(8'b1000_0011, 0, 1'b1);
        send(8'b1000_0011, 7, 1'b0);
        drain(50);
        check("stream_count", 32'(pop_cyc.size() - n0), 32'd4);
        if (pop_cyc.size() - n0 == 4) begin
            for (int i = 0; i < 3; i++)
                check("stream_gap", 32'(pop_cyc[n0+i+1] - pop_cyc[n0+i]), 32'd1);
        end

        // Backpressure: three beats fill the pipe, the fourth waits for out_ready
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            send(W'($urandom), int'($urandom_range(0, W-1)), 1'($urandom_range(0, 1)));
        bd       = 8'hA5;
        in_valid = 1'b1;
        in_data  = bd;
        in_amt   = '0;
        in_dir   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready_low", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_busy", 32'(busy), 32'd1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_in_ready_rise", 32'(in_ready), 32'd1);
        exp_q.push_back(model(int'(bd), 0, 1'b0));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        drain(50);

        // Reset with two beats in flight clears everything immediately
        send(8'h3C, 5, 1'b0);
        send(8'h96, 2, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_out_valid", 32'(out_valid), 32'd0);
        check("rst_mid_out_data", 32'(out_data), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("rst_no_stale", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;

        // Exhaustive sweep with random downstream stalls
        rnd_or = 1'b1;
        for (int dir = 0; dir < 2; dir++)
            for (int k = 0; k < W; k++)
                for (int d = 0; d < 256; d++)
                    send(W'(d), k, 1'(dir));
        drain(2000);
        rnd_or = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("final_busy", 32'(busy), 32'd0);
        check("final_scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
